// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the
// instruction-memory loader.
package imem_pkg;

  localparam int IMEM_AW    = 6;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } ld_state_e;

endpackage

// File: rtl/word_packer.sv
// Byte-serial to word packer: shifts bytes in MSB-first and
// flags the byte that completes a word.
//   clk, reset   : clock, sync active-high reset
//   clear_i      : restart byte count for a new load
//   shift_en_i   : accept byte_i this cycle
//   byte_i       : incoming byte
//   word_o       : assembled word register
//   word_ready_o : the byte being accepted completes the word
module word_packer #(
  parameter int DW = imem_pkg::IMEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          shift_en_i,
  input  logic [7:0]    byte_i,
  output logic [DW-1:0] word_o,
  output logic          word_ready_o
);

  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [DW-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      word_d = {word_q[DW-9:0], byte_i};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = shift_en_i && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into the instruction memory write port.
//   clk, reset     : clock, sync active-high reset
//   start          : begin load of num_words (ignored mid-load)
//   in_valid/byte  : byte stream, MSB byte first; in_ready accepts
//   mem_we/a/wd    : one-cycle write strobe, word address, data
//   busy, done     : load in progress / load complete (held)
//   words_written  : words written in current or last load
module imem_loader #(
  parameter int IMEM_AW = imem_pkg::IMEM_AW,
  parameter int IMEM_DW = imem_pkg::IMEM_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [6:0]         num_words,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_a,
  output logic [IMEM_DW-1:0] mem_wd,
  output logic               busy,
  output logic               done,
  output logic [6:0]         words_written
);

  import imem_pkg::*;

  localparam logic [6:0] MAXW = 7'(IMEM_DEPTH);

  ld_state_e          state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [6:0]         ww_q, ww_d;
  logic [6:0]         tgt_q, tgt_d;
  logic [6:0]         ww_inc;
  logic [6:0]         sat_n;
  logic               accept;
  logic               pk_clear;
  logic               word_ready;
  logic [IMEM_DW-1:0] word;

  assign accept = (state_q == S_COLLECT) && in_valid;
  assign ww_inc = ww_q + 7'd1;
  assign sat_n  = (num_words > MAXW) ? MAXW : num_words;

  word_packer #(.DW(IMEM_DW)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .shift_en_i   (accept),
    .byte_i       (in_byte),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ww_d     = ww_q;
    tgt_d    = tgt_q;
    pk_clear = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pk_clear = 1'b1;
          addr_d   = '0;
          ww_d     = '0;
          tgt_d    = sat_n;
          state_d  = (num_words == 7'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (word_ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        ww_d = ww_inc;
        // Address holds on the final word so it never wraps.
        if (ww_inc == tgt_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ww_q    <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ww_q    <= ww_d;
      tgt_q   <= tgt_d;
    end
  end

  assign in_ready      = (state_q == S_COLLECT);
  assign mem_we        = (state_q == S_WRITE);
  assign busy          = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign mem_a         = addr_q;
  assign mem_wd        = word;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver queues expected
// writes, negedge monitor pops and compares them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_a;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic [6:0]  words_written;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_a         (mem_a),
    .mem_wd        (mem_wd),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] preset_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop plus write-latency expectation.
  int   acc_cnt = 0;
  logic exp_we_next = 1'b0;
  wr_t  e;

  always @(negedge clk) begin
    if (mem_we || exp_we_next)
      chk("we_latency", {31'd0, mem_we}, {31'd0, exp_we_next});
    if (mem_we) begin
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mem_a", {26'd0, mem_a}, {26'd0, e.a});
        chk("mem_wd", mem_wd, e.d);
      end
    end
    if (reset || (start && !busy)) begin
      acc_cnt     = 0;
      exp_we_next = 1'b0;
    end else begin
      exp_we_next = in_valid && in_ready && (acc_cnt % 4 == 3);
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int n);
    start     = 1'b1;
    num_words = 7'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    int w = 0;
    bit got = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!got && w < 50) begin
      @(negedge clk);
      if (in_ready) got = 1;
      w++;
    end
    if (!got) chk("byte_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_a"}, {26'd0, mem_a}, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_ww"}, {25'd0, words_written}, 32'd0);
  endtask

  // Full load: model words from the byte list, stream them,
  // optionally pulse an ignored start before byte ign_at.
  task automatic run_load(int n, int gap, int extra, int ign_at);
    int tgt;
    int w;
    logic [7:0] bytes[$];
    wr_t x;
    tgt = (n > 64) ? 64 : n;
    for (int i = 0; i < tgt * 4; i++) begin
      if (preset_q.size() != 0) bytes.push_back(preset_q.pop_front());
      else bytes.push_back(8'($urandom));
    end
    for (int k = 0; k < tgt; k++) begin
      x.a = 6'(k);
      x.d = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
      exp_q.push_back(x);
    end
    pulse_start(n);
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == ign_at) begin
        start     = 1'b1;
        num_words = 7'd5;
        tick();
        start = 1'b0;
      end
      send_byte(bytes[i], gap);
    end
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("words_written", {25'd0, words_written}, 32'(tgt));
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b1;
    repeat (extra) begin
      @(negedge clk);
      chk("no_accept_done", {31'd0, in_ready}, 32'd0);
    end
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    preset_q = '{8'h8C, 8'h01, 8'h00, 8'h04};
    run_load(1, 0, 2, -1);

    run_load(3, 2, 0, -1);

    pulse_start(0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_ww", {25'd0, words_written}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();

    run_load(100, 0, 6, -1);

    // Reset after word 0 plus 2 bytes of word 1.
    begin
      wr_t x;
      x.a = 6'd0;
      x.d = 32'h11223344;
      exp_q.push_back(x);
      pulse_start(2);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 1);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      exp_q.delete();
      reset    = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      tick();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      check_reset_vals("midrst");
      repeat (6) tick();
      check_reset_vals("idle");
    end

    run_load(2, 1, 0, 2);

    for (int r = 0; r < 4; r++)
      run_load($urandom_range(1, 6), $urandom_range(0, 3), 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: IMEM_AW, default 6, instruction memory word-address width.
REQ-002 Parameter: IMEM_DW, default 32, instruction word width.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; begins a load of num_words words.
REQ-007 num_words  input  7  word count for the load, sampled only on the accepted start.
REQ-008 in_valid  input  1  in_byte carries a valid byte.
REQ-009 in_byte  input  8  serial program byte stream, MSB byte of each word first.
REQ-010 in_ready  output  1  loader accepts in_byte this cycle.
REQ-011 mem_we  output  1  write strobe to instruction memory.
REQ-012 mem_a  output  6  word address to instruction memory.
REQ-013 mem_wd  output  32  write data to instruction memory.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load complete, held.
REQ-016 words_written  output  7  count of words written in the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: in_ready=0, busy=0, done=0; start=1 moves to COLLECT with addr=0, byte_cnt=0, words_written=0, target=num_words.
REQ-019 start with num_words=0 SHALL go to DONE directly, writing nothing, words_written=0.
REQ-020 num_words>64 SHALL saturate target to 64.
REQ-021 COLLECT: in_ready=1, busy=1; byte accepted only when in_valid && in_ready on a rising edge.
REQ-022 Each accepted byte SHALL shift into the word register: word <= {word[23:0], in_byte}; byte_cnt increments mod 4.
REQ-023 Acceptance of the 4th byte SHALL move to WRITE on the same edge.
REQ-024 in_valid=0 in COLLECT SHALL hold all state (no timeout).
REQ-025 WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_a=addr, mem_wd=assembled word.
REQ-026 Latency: mem_we SHALL assert in the cycle immediately after the 4th byte is accepted.
REQ-027 Leaving WRITE: addr and words_written increment; if new words_written==target go to DONE, else COLLECT.
REQ-028 addr SHALL never wrap; a 64-word load ends at addr 63 written, then DONE.
REQ-029 DONE: done=1, busy=0, in_ready=0, words_written held; start=1 restarts exactly as from IDLE.
REQ-030 start while in COLLECT or WRITE SHALL be ignored.
REQ-031 mem_we SHALL be 0 in every state except WRITE; mem_a/mem_wd are don't-care when mem_we=0 but registered.
REQ-032 All outputs SHALL be driven from registers or state decode only; no combinational path from in_valid to in_ready.

Reset
REQ-033 reset=1 SHALL force IDLE, in_ready=0, mem_we=0, mem_a=0, mem_wd=0, busy=0, done=0, words_written=0, byte_cnt=0 on the next edge.
REQ-034 reset mid-load (any state) SHALL abandon the load; partially collected bytes are discarded, no mem_we issued.
REQ-035 reset SHALL take priority over start and in_valid in the same cycle.

Structure
REQ-036 Package imem_pkg SHALL hold IMEM_AW, IMEM_DW, IMEM_DEPTH=64 and the loader state enum.
REQ-037 A sub-module word_packer (byte shift register + byte_cnt, word_ready flag) is natural; the FSM and address counter stay in imem_loader.
REQ-038 imem_loader SHALL target the write port of the instruction memory; read-side imem remains unchanged.

Verification
REQ-039 start, num_words=1, bytes 8C,01,00,04 back-to-back -> single mem_we, mem_a=0, mem_wd=8C010004, done=1, words_written=1.
REQ-040 num_words=3, 12 bytes with in_valid gaps of 2 cycles -> writes at addr 0,1,2 in order, in_ready=0 during each WRITE cycle.
REQ-041 num_words=0 -> DONE next cycle, no mem_we, words_written=0.
REQ-042 num_words=100, stream 256 bytes -> exactly 64 writes, last mem_a=63, done=1, bytes after 256th not accepted.
REQ-043 reset asserted after 2 bytes of word 1 in a 2-word load -> IDLE next cycle, no further mem_we, all outputs at reset values.
REQ-044 start pulse during COLLECT of word 0 with num_words=5 -> ignored, load completes with words_written=2 from original num_words=2.
